// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, write-through bypass
// and a sequential clear engine that wipes one entry per cycle.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     WR,
    input  logic [ADDR_W-1:0]        DSEL,
    input  logic [DATA_W-1:0]        DIN,
    input  logic [NUM_RD*ADDR_W-1:0] RSEL,
    output logic [NUM_RD*DATA_W-1:0] ROUT,
    output logic                     busy,
    output logic                     wr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic clr_go;
    logic wr_zero;
    logic wr_ok;
    logic wr_bad;

    always_comb begin
        clr_go  = (state == IDLE) && clear;
        wr_zero = (ZERO_REG != 0) && (DSEL == '0);
        wr_ok   = !reset && (state == IDLE) && WR && !clear && !wr_zero;
        wr_bad  = !reset && WR && ((state == CLEAR) || clr_go);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= CLEAR;
            ptr    <= '0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            wr_err <= wr_err | wr_bad;
        end
    end

    // Array is left untouched while reset is held; wiping starts after release.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_ok) begin
                mem[DSEL] <= DIN;
            end
        end
    end

    assign busy = (state == CLEAR);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rs;
        assign rs = RSEL[i*ADDR_W +: ADDR_W];
        assign ROUT[i*DATA_W +: DATA_W] =
            ((ZERO_REG != 0) && (rs == '0))         ? '0  :
            ((BYPASS != 0) && wr_ok && (DSEL == rs)) ? DIN :
                                                       mem[rs];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default build, a no-bypass
// build sharing the same stimulus, and a narrow 4-port build without zero reg.
module tb_reg_file_mp;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        wr;
    logic [4:0]  dsel;
    logic [31:0] din;
    logic [9:0]  rsel;
    logic [63:0] rout;
    logic        busy;
    logic        wr_err;
    logic [63:0] rout_nb;
    logic        busy_nb;
    logic        wr_err_nb;

    logic        s_reset;
    logic        s_clear;
    logic        s_wr;
    logic [2:0]  s_dsel;
    logic [15:0] s_din;
    logic [11:0] s_rsel;
    logic [63:0] s_rout;
    logic        s_busy;
    logic        s_wr_err;

    int errs;
    int checks;

    reg_file_mp dut (
        .clock(clock), .reset(reset), .clear(clear), .WR(wr),
        .DSEL(dsel), .DIN(din), .RSEL(rsel), .ROUT(rout),
        .busy(busy), .wr_err(wr_err)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .clear(clear), .WR(wr),
        .DSEL(dsel), .DIN(din), .RSEL(rsel), .ROUT(rout_nb),
        .busy(busy_nb), .wr_err(wr_err_nb)
    );

    reg_file_mp #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1)
    ) dut_s (
        .clock(clock), .reset(s_reset), .clear(s_clear), .WR(s_wr),
        .DSEL(s_dsel), .DIN(s_din), .RSEL(s_rsel), .ROUT(s_rout),
        .busy(s_busy), .wr_err(s_wr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clock);
        wr = 1'b1; dsel = a; din = d;
        @(negedge clock);
        wr = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_state busy=%b wr_err=%b want 1 0", busy, wr_err);
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 32) begin
            errs++;
            $display("FAIL reset_busy_len got=%0d want=32", n);
        end
        checks++;
        if (busy_nb !== 1'b0) begin
            errs++;
            $display("FAIL reset_nb_busy got=%b want 0", busy_nb);
        end
        for (int a = 0; a < 32; a++) begin
            rsel = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (rout !== 64'd0) begin
                errs++;
                $display("FAIL reset_zero r%0d got=%h want 0", a, rout);
            end
        end
        checks++;
        if (wr_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_wr_err got=%b want 0", wr_err);
        end
    endtask

    task automatic test_write;
        wr_reg(5'd5, 32'hDEADBEEF);
        rsel = {5'd5, 5'd5};
        #1;
        checks++;
        if (rout !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL write_r5 got=%h want deadbeefdeadbeef", rout);
        end
        wr_reg(5'd0, 32'h1234);
        rsel = {5'd5, 5'd0};
        #1;
        checks++;
        if (rout !== {32'hDEADBEEF, 32'h0} || wr_err !== 1'b0) begin
            errs++;
            $display("FAIL write_r0 got=%h err=%b want deadbeef00000000 0",
                     rout, wr_err);
        end
    endtask

    task automatic test_bypass;
        wr_reg(5'd7, 32'h77);
        wr_reg(5'd8, 32'h88);
        @(negedge clock);
        wr = 1'b1; dsel = 5'd7; din = 32'hA5A5A5A5;
        rsel = {5'd8, 5'd7};
        #1;
        checks++;
        if (rout !== {32'h88, 32'hA5A5A5A5}) begin
            errs++;
            $display("FAIL bypass_on got=%h want 00000088a5a5a5a5", rout);
        end
        checks++;
        if (rout_nb !== {32'h88, 32'h77}) begin
            errs++;
            $display("FAIL bypass_off got=%h want 0000008800000077", rout_nb);
        end
        @(negedge clock);
        wr = 1'b0;
        #1;
        checks++;
        if (rout_nb !== {32'h88, 32'hA5A5A5A5}) begin
            errs++;
            $display("FAIL bypass_off_next got=%h want 00000088a5a5a5a5",
                     rout_nb);
        end
    endtask

    task automatic test_clear;
        int n;
        for (int i = 1; i < 32; i++) begin
            wr_reg(5'(i), 32'(i * 3));
        end
        rsel = {5'd31, 5'd10};
        #1;
        checks++;
        if (rout !== {32'd93, 32'd30}) begin
            errs++;
            $display("FAIL fill got=%h want 0000005d0000001e", rout);
        end
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL clear_start busy=%b want 1", busy);
        end
        n = 0;
        while (busy && n < 100) begin
            if (n == 3) clear = 1'b1;
            if (n == 9) begin
                wr = 1'b1; dsel = 5'd4; din = 32'd9;
            end
            @(negedge clock);
            n++;
            clear = 1'b0;
            wr = 1'b0;
            if (n == 5) begin
                rsel = {5'd20, 5'd2};
                #1;
                checks++;
                if (rout !== {32'd60, 32'd0}) begin
                    errs++;
                    $display("FAIL clear_partial got=%h want 0000003c00000000",
                             rout);
                end
            end
            if (n == 10) begin
                checks++;
                if (wr_err !== 1'b1 || wr_err_nb !== 1'b1) begin
                    errs++;
                    $display("FAIL clear_wr_err got=%b%b want 11",
                             wr_err, wr_err_nb);
                end
            end
        end
        checks++;
        if (n !== 32) begin
            errs++;
            $display("FAIL clear_len got=%0d want=32", n);
        end
        for (int a = 0; a < 32; a++) begin
            rsel = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (rout !== 64'd0) begin
                errs++;
                $display("FAIL clear_zero r%0d got=%h want 0", a, rout);
            end
        end
        checks++;
        if (wr_err !== 1'b1) begin
            errs++;
            $display("FAIL wr_err_sticky got=%b want 1", wr_err);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        wr_reg(5'd20, 32'h20);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int k = 0; k < 17; k++) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clock);
        reset = 1'b0;
        rsel = {5'd20, 5'd20};
        #1;
        checks++;
        if (busy !== 1'b1 || wr_err !== 1'b0) begin
            errs++;
            $display("FAIL midrst_state busy=%b wr_err=%b want 1 0",
                     busy, wr_err);
        end
        checks++;
        if (rout !== {32'h20, 32'h20}) begin
            errs++;
            $display("FAIL midrst_r20 got=%h want 0000002000000020", rout);
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 32) begin
            errs++;
            $display("FAIL midrst_len got=%0d want=32", n);
        end
        #1;
        checks++;
        if (rout !== 64'd0) begin
            errs++;
            $display("FAIL midrst_r20_cleared got=%h want 0", rout);
        end
    endtask

    task automatic test_sweep;
        int n;
        @(negedge clock);
        s_reset = 1'b1;
        @(negedge clock);
        s_reset = 1'b0;
        n = 0;
        while (s_busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 8) begin
            errs++;
            $display("FAIL sweep_len got=%0d want=8", n);
        end
        s_wr = 1'b1; s_dsel = 3'd0; s_din = 16'hBEEF; s_rsel = '0;
        #1;
        checks++;
        if (s_rout !== {4{16'hBEEF}}) begin
            errs++;
            $display("FAIL sweep_bypass got=%h want beefbeefbeefbeef", s_rout);
        end
        @(negedge clock);
        s_wr = 1'b0;
        #1;
        checks++;
        if (s_rout !== {4{16'hBEEF}} || s_wr_err !== 1'b0) begin
            errs++;
            $display("FAIL sweep_r0 got=%h err=%b want beefbeefbeefbeef 0",
                     s_rout, s_wr_err);
        end
    endtask

    initial begin
        errs = 0;
        checks = 0;
        reset = 1'b0; clear = 1'b0; wr = 1'b0;
        dsel = '0; din = '0; rsel = '0;
        s_reset = 1'b0; s_clear = 1'b0; s_wr = 1'b0;
        s_dsel = '0; s_din = '0; s_rsel = '0;
        test_reset;
        test_write;
        test_bypass;
        test_clear;
        test_reset_mid_clear;
        test_sweep;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file for the CPU datapath. It is the successor to the current 2-read/1-write 32x32 file.
- Writes are synchronous. Reads are combinational, with optional write-through bypass.
- Register 0 can be hard-wired to zero.
- Contents are wiped by a sequential clear engine, one entry per cycle, after reset or on request. Reset does not need to be held for DEPTH cycles.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..8).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of the address being written this cycle returns DIN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; starts a full clear.
- clear  in  1  single-cycle request to start a full clear when idle.
- WR  in  1  write enable.
- DSEL  in  ADDR_W  write address.
- DIN  in  DATA_W  write data.
- RSEL  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- ROUT  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- busy  out  1  high while the clear engine runs.
- wr_err  out  1  sticky flag: a write was attempted while busy.

Behaviour:
- FSM has two states, IDLE and CLEAR, with a pointer ptr[ADDR_W-1:0].
- Reset (sampled at a rising edge):
  - state=CLEAR, ptr=0, busy=1, wr_err=0.
  - Array contents are not changed in the reset cycle itself.
  - While reset stays high, the block holds CLEAR with ptr=0.
- CLEAR, per cycle:
  - mem[ptr] <= 0 and ptr <= ptr+1.
  - When ptr==DEPTH-1, that entry is cleared and the next state is IDLE, with busy=0 and ptr=0.
  - busy therefore deasserts exactly DEPTH rising edges after the first edge with reset low (32 for the default).
- IDLE with clear=1: the next state is CLEAR with ptr=0.
- clear=1 while already in CLEAR is ignored; it does not restart the pointer.
- Write:
  - In IDLE, with WR=1, not in reset, and not (ZERO_REG && DSEL==0): mem[DSEL] <= DIN at the edge.
  - WR=1 with DSEL==0 and ZERO_REG=1 is silently dropped and does not set wr_err.
- Write during busy or clear-start:
  - If WR=1 in a cycle where busy=1, or in the same IDLE cycle that clear=1 is accepted, the write is dropped and wr_err <= 1.
  - wr_err clears only on reset.
  - Clear has priority over a simultaneous write.
- Read, port i (combinational, no latency):
  - ZERO_REG && RSEL_i==0 gives 0.
  - Otherwise, if BYPASS and the write qualifies this cycle (IDLE, WR, not reset, no clear accepted, DSEL==RSEL_i, not dropped as a zero-register write), the output is DIN.
  - Otherwise the output is mem[RSEL_i].
- Reads during CLEAR return current array contents: 0 for entries below ptr, old values otherwise. Consumers must not rely on them until busy=0.
- Multiple read ports may select the same address; every port returns the same value.
- Power-up before the first reset: contents are undefined. Simulation initial values are not part of the contract.
- No combinational path from RSEL to busy or wr_err.

Test Plan:
- Reset 1 cycle, then release; count edges -> busy=1 for exactly 32 cycles after release, then 0. All 32 entries read 0 on ROUT ports 0/1. wr_err=0.
- IDLE: write 0xDEADBEEF to r5. Next cycle RSEL0=5, RSEL1=5 -> both ROUT=0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0, wr_err=0.
- Bypass: WR=1, DSEL=7, DIN=0xA5A5A5A5, RSEL0=7, RSEL1=8 in the same cycle -> ROUT0=0xA5A5A5A5 combinationally, ROUT1=old r8. Rebuild with BYPASS=0 -> ROUT0=old r7 in that cycle, new value the following cycle.
- Fill r1..r31 with index*3. Pulse clear -> busy rises the next cycle. WR=1 DSEL=4 DIN=9 at cycle 10 of the clear is dropped and wr_err=1. After 32 cycles, all entries read 0.
- Reset mid-clear at ptr=17, held 3 cycles -> ptr restarts at 0, busy stays 1 for 32 cycles after release, wr_err cleared.
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=0 -> clear lasts 8 cycles. Write 0xBEEF to r0 -> r0 reads 0xBEEF on all 4 ports.
